param_pow_pipe: RTL

PARAM_POW_PIPE -- requirements
Module: param_pow_pipe

---
 rtl/param_pow_pkg.sv | 10 +
 rtl/param_pow_pipe_stage.sv | 58 +++++
 rtl/param_pow_pipe.sv | 73 +++++++
 3 files changed

// File: rtl/param_pow_pkg.sv
// Shared constants for the square-and-multiply power pipeline.
// Defaults for widths and the resulting pipeline latency.
package param_pow_pkg;

    localparam int DEF_DATA_W   = 7;
    localparam int DEF_EXP_BITS = 4;
    localparam int DEF_OUT_W    = 64;
    localparam int LATENCY      = DEF_EXP_BITS;

endpackage

// File: rtl/param_pow_pipe_stage.sv
// One square-and-multiply step: stage K consumes exponent bit K.
// Products are formed at double width so the high half flags overflow.
module pow_stage
    import param_pow_pkg::*;
#(
    parameter int OUT_W    = DEF_OUT_W,
    parameter int EXP_BITS = DEF_EXP_BITS,
    parameter int K        = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                valid,
    input  logic [OUT_W-1:0]    acc,
    input  logic [OUT_W-1:0]    base,
    input  logic [EXP_BITS-1:0] exp,
    input  logic                ovf,
    input  logic                bovf,
    output logic                valid_q,
    output logic [OUT_W-1:0]    acc_q,
    output logic [OUT_W-1:0]    base_q,
    output logic [EXP_BITS-1:0] exp_q,
    output logic                ovf_q,
    output logic                bovf_q
);

    logic [2*OUT_W-1:0] p_mul;
    logic [2*OUT_W-1:0] p_sq;
    logic               mul_hi;
    logic               sq_hi;
    logic               bit_k;

    assign p_mul  = {{OUT_W{1'b0}}, acc} * {{OUT_W{1'b0}}, base};
    assign p_sq   = {{OUT_W{1'b0}}, base} * {{OUT_W{1'b0}}, base};
    assign mul_hi = |p_mul[2*OUT_W-1:OUT_W];
    assign sq_hi  = |p_sq[2*OUT_W-1:OUT_W];
    assign bit_k  = exp[K];

    // Register the step result; everything holds while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            bovf_q  <= 1'b0;
        end else if (en) begin
            valid_q <= valid;
            acc_q   <= bit_k ? p_mul[OUT_W-1:0] : acc;
            base_q  <= p_sq[OUT_W-1:0];
            exp_q   <= exp;
            ovf_q   <= ovf | (bit_k & (bovf | mul_hi));
            bovf_q  <= bovf | sq_hi;
        end
    end

endmodule

// File: rtl/param_pow_pipe.sv
// x^e mod 2^OUT_W with overflow flag, one stage per exponent bit.
// A single global enable advances or freezes the whole pipe.
module param_pow_pipe
    import param_pow_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int EXP_BITS = DEF_EXP_BITS,
    parameter int OUT_W    = DEF_OUT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [EXP_BITS-1:0] i_exp,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_valid,
    output logic [OUT_W-1:0]    o_data,
    output logic                o_ovf,
    input  logic                i_ready
);

    logic                en;
    logic                vld_s  [EXP_BITS+1];
    logic [OUT_W-1:0]    acc_s  [EXP_BITS+1];
    logic [OUT_W-1:0]    base_s [EXP_BITS+1];
    logic [EXP_BITS-1:0] exp_s  [EXP_BITS+1];
    logic                ovf_s  [EXP_BITS+1];
    logic                bovf_s [EXP_BITS+1];
    logic                unused_tail;

    // Stall only when a result is waiting and downstream refuses it.
    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    assign vld_s[0]  = i_valid;
    assign acc_s[0]  = OUT_W'(1);
    assign base_s[0] = OUT_W'(i_data);
    assign exp_s[0]  = i_exp;
    assign ovf_s[0]  = 1'b0;
    assign bovf_s[0] = 1'b0;

    for (genvar k = 0; k < EXP_BITS; k++) begin : g_stage
        pow_stage #(
            .OUT_W    (OUT_W),
            .EXP_BITS (EXP_BITS),
            .K        (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .valid   (vld_s[k]),
            .acc     (acc_s[k]),
            .base    (base_s[k]),
            .exp     (exp_s[k]),
            .ovf     (ovf_s[k]),
            .bovf    (bovf_s[k]),
            .valid_q (vld_s[k+1]),
            .acc_q   (acc_s[k+1]),
            .base_q  (base_s[k+1]),
            .exp_q   (exp_s[k+1]),
            .ovf_q   (ovf_s[k+1]),
            .bovf_q  (bovf_s[k+1])
        );
    end

    assign o_valid = vld_s[EXP_BITS];
    assign o_data  = acc_s[EXP_BITS];
    assign o_ovf   = ovf_s[EXP_BITS];

    assign unused_tail = ^{base_s[EXP_BITS], exp_s[EXP_BITS],
                           bovf_s[EXP_BITS]};

endmodule
